stopwatch_core: RTL



---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_core_if.sv | 25 ++
 rtl/stopwatch_core_rise_detect.sv | 23 ++
 rtl/stopwatch_core.sv | 136 +++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned PRESC_W = 16;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] MIN_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;

  // Returns {carry, next_digit}; anything at or above max rolls to zero.
  function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] digit,
                                               input logic [BCD_W-1:0] max);
    if (digit >= max) begin
      return {1'b1, {BCD_W{1'b0}}};
    end
    return {1'b0, digit + 4'd1};
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control inputs and BCD display outputs of the stopwatch core.
interface stopwatch_core_if;
  import stopwatch_pkg::*;

  logic             tick_in;
  logic             btn_start_stop;
  logic             btn_clear;
  logic [BCD_W-1:0] sec_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] min_tens;
  logic             running;
  logic             wrap;

  modport master (
    output tick_in, btn_start_stop, btn_clear,
    input  sec_ones, sec_tens, min_ones, min_tens, running, wrap
  );

  modport slave (
    input  tick_in, btn_start_stop, btn_clear,
    output sec_ones, sec_tens, min_ones, min_tens, running, wrap
  );

endinterface

// File: rtl/stopwatch_core_rise_detect.sv
// Rising-edge detector for a level already synchronous to clk.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch driven by edges of the divided count clock and two buttons.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_COUNT = 1
) (
  input logic              clk,
  input logic              reset,
  stopwatch_core_if.slave  bus
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_COUNT - 1);

  logic tick_rise, ss_rise, clear_rise;

  // Previous-value flops reset high so inputs held at reset release give no edge.
  rise_detect #(.RESET_VAL(1'b1)) u_tick_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.tick_in),
    .rise  (tick_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_ss_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_start_stop),
    .rise  (ss_rise)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_clear_rise (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_clear),
    .rise  (clear_rise)
  );

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BCD_W-1:0]   sec_ones_q, sec_ones_d;
  logic [BCD_W-1:0]   sec_tens_q, sec_tens_d;
  logic [BCD_W-1:0]   min_ones_q, min_ones_d;
  logic [BCD_W-1:0]   min_tens_q, min_tens_d;
  logic               running_q, running_d;
  logic               wrap_q, wrap_d;
  logic               inc, c0, c1, c2, c3;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    wrap_d     = 1'b0;
    inc        = 1'b0;
    c0         = 1'b0;
    c1         = 1'b0;
    c2         = 1'b0;
    c3         = 1'b0;

    if (clear_rise) begin
      state_d    = IDLE;
      presc_d    = '0;
      sec_ones_d = '0;
      sec_tens_d = '0;
      min_ones_d = '0;
      min_tens_d = '0;
    end else begin
      // Decided on the current state, so a tick is counted in the cycle that leaves RUN.
      if (state_q == RUN && tick_rise) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          inc     = 1'b1;
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end

      if (inc) begin
        {c0, sec_ones_d} = bcd_step(sec_ones_q, DIGIT_MAX);
        if (c0) begin
          {c1, sec_tens_d} = bcd_step(sec_tens_q, SEC_TENS_MAX);
          if (c1) begin
            {c2, min_ones_d} = bcd_step(min_ones_q, DIGIT_MAX);
            if (c2) begin
              {c3, min_tens_d} = bcd_step(min_tens_q, MIN_TENS_MAX);
              wrap_d = c3;
            end
          end
        end
      end

      if (ss_rise) begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.sec_ones = sec_ones_q;
  assign bus.sec_tens = sec_tens_q;
  assign bus.min_ones = min_ones_q;
  assign bus.min_tens = min_tens_q;
  assign bus.running  = running_q;
  assign bus.wrap     = wrap_q;

endmodule
